// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    OPEN  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } lock_state_e;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LS = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker with a per-port eligibility mask.
module rr_pick2
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic [1:0] mask,
  output logic [1:0] gnt
);

  logic [1:0] elig;

  assign elig = req & mask;

  // On a tie the port that did not win the last accepted transfer goes first.
  always_comb begin
    gnt = 2'b00;
    if (elig == 2'b11) begin
      gnt = (last == PORT_LS) ? 2'b01 : 2'b10;
    end else begin
      gnt = elig;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch (port 0)
// and load/store (port 1), with round-robin fairness and an atomic lock.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DataWidth = 8,
  parameter int AddrWidth = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic                 lock0,
  input  logic                 lock1,
  input  logic [AddrWidth-1:0] addr0,
  input  logic [AddrWidth-1:0] addr1,
  input  logic [DataWidth-1:0] wdata0,
  input  logic [DataWidth-1:0] wdata1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 rvalid0,
  output logic                 rvalid1,
  output logic [DataWidth-1:0] rdata0,
  output logic [DataWidth-1:0] rdata1,
  output logic [AddrWidth-1:0] ram_addr,
  output logic [DataWidth-1:0] ram_wdata,
  output logic                 ram_we,
  input  logic [DataWidth-1:0] ram_data
);

  lock_state_e state_q, state_d;
  logic        last_gnt_q, last_gnt_d;
  logic        rvalid0_q, rvalid0_d;
  logic        rvalid1_q, rvalid1_d;
  logic [1:0]  mask;
  logic [1:0]  pick;

  // A held lock restricts eligibility to its owner; a dropped lock reopens arbitration.
  always_comb begin
    mask = 2'b11;
    case (state_q)
      LOCK0:   if (lock0) mask = 2'b01;
      LOCK1:   if (lock1) mask = 2'b10;
      default: mask = 2'b11;
    endcase
  end

  rr_pick2 u_pick (
    .req  ({req1, req0}),
    .last (last_gnt_q),
    .mask (mask),
    .gnt  (pick)
  );

  // Grants are suppressed during reset so no RAM access leaks out.
  assign gnt0 = pick[PORT_IF] & rst_n;
  assign gnt1 = pick[PORT_LS] & rst_n;

  // Route the granted port to the RAM; idle cycles drive zeros.
  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    if (gnt0) begin
      ram_addr  = addr0;
      ram_wdata = wdata0;
      ram_we    = we0;
    end else if (gnt1) begin
      ram_addr  = addr1;
      ram_wdata = wdata1;
      ram_we    = we1;
    end
  end

  // Next lock state, round-robin history and read-return flags.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    rvalid0_d  = gnt0 & ~we0;
    rvalid1_d  = gnt1 & ~we1;
    if (gnt0) begin
      last_gnt_d = PORT_IF;
      state_d    = lock0 ? LOCK0 : OPEN;
    end else if (gnt1) begin
      last_gnt_d = PORT_LS;
      state_d    = lock1 ? LOCK1 : OPEN;
    end else if ((state_q == LOCK0 && !lock0) || (state_q == LOCK1 && !lock1)) begin
      state_d = OPEN;
    end
  end

  // Lock FSM with its registered outputs; reset lets port 0 win the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= OPEN;
      last_gnt_q <= PORT_LS;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = ram_data;
  assign rdata1  = ram_data;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM, vector table and read-data scoreboard.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1, we0, we1, lock0, lock1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata0, rdata1;
  logic [7:0] ram_addr, ram_wdata, ram_data;
  logic       ram_we;

  logic [7:0] ram_mem [256];
  logic [7:0] exp_mem [256];
  logic [7:0] ram_raddr_q;

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  int passed = 0;
  int total  = 0;

  typedef struct {
    string      name;
    logic       r0, w0, l0;
    logic [7:0] a0, d0;
    logic       r1, w1, l1;
    logic [7:0] a1, d1;
    logic       g0, g1;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  ram_arbiter #(.DataWidth(8), .AddrWidth(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_data(ram_data)
  );

  // Single-port RAM with registered read address.
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_raddr_q <= ram_addr;
  end
  assign ram_data = ram_mem[ram_raddr_q];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  function automatic vec_t mk(input string nm,
                              input logic r0, input logic w0, input logic l0,
                              input logic [7:0] a0, input logic [7:0] d0,
                              input logic r1, input logic w1, input logic l1,
                              input logic [7:0] a1, input logic [7:0] d1,
                              input logic g0, input logic g1);
    vec_t v;
    v.name = nm;
    v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1;
    return v;
  endfunction

  task automatic check_rv(input string nm);
    if (q0.size() > 0) begin
      chk({nm, " rvalid0"}, rvalid0, 1);
      chk({nm, " rdata0"}, rdata0, q0.pop_front());
    end else begin
      chk({nm, " rvalid0"}, rvalid0, 0);
    end
    if (q1.size() > 0) begin
      chk({nm, " rvalid1"}, rvalid1, 1);
      chk({nm, " rdata1"}, rdata1, q1.pop_front());
    end else begin
      chk({nm, " rvalid1"}, rvalid1, 0);
    end
  endtask

  // Called at a falling edge: drive, check grants and RAM drive, then check read return.
  task automatic apply(input vec_t v);
    logic [7:0] ea, ed;
    logic       ewe;
    req0 = v.r0; we0 = v.w0; lock0 = v.l0; addr0 = v.a0; wdata0 = v.d0;
    req1 = v.r1; we1 = v.w1; lock1 = v.l1; addr1 = v.a1; wdata1 = v.d1;
    #2;
    chk({v.name, " gnt0"}, gnt0, v.g0);
    chk({v.name, " gnt1"}, gnt1, v.g1);
    ea = 8'h00; ed = 8'h00; ewe = 1'b0;
    if (v.g0) begin
      ea = v.a0; ed = v.d0; ewe = v.w0;
      if (v.w0) exp_mem[v.a0] = v.d0;
      else q0.push_back(exp_mem[v.a0]);
    end else if (v.g1) begin
      ea = v.a1; ed = v.d1; ewe = v.w1;
      if (v.w1) exp_mem[v.a1] = v.d1;
      else q1.push_back(exp_mem[v.a1]);
    end
    chk({v.name, " ram_we"}, ram_we, ewe);
    chk({v.name, " ram_addr"}, ram_addr, ea);
    chk({v.name, " ram_wdata"}, ram_wdata, ed);
    @(posedge clk);
    #1;
    check_rv(v.name);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = 8'(i * 3 + 1);
      exp_mem[i] = 8'(i * 3 + 1);
    end
    ram_mem[8'h10] = 8'hA5;
    exp_mem[8'h10] = 8'hA5;

    //           name          r0 w0 l0 a0     d0     r1 w1 l1 a1     d1     g0 g1
    tbl.push_back(mk("rd0_a5",   1, 0, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 0));
    tbl.push_back(mk("idle_a",   0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk("rd1_solo", 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h40, 8'h00, 0, 1));
    tbl.push_back(mk("rr_a",     1, 0, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00, 1, 0));
    tbl.push_back(mk("rr_b",     1, 0, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00, 0, 1));
    tbl.push_back(mk("rr_c",     1, 0, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00, 1, 0));
    tbl.push_back(mk("rr_d",     1, 0, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00, 0, 1));
    tbl.push_back(mk("wr1_3c",   0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h20, 8'h3C, 0, 1));
    tbl.push_back(mk("rd0_20",   1, 0, 0, 8'h20, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 0));
    tbl.push_back(mk("lk1_rd",   1, 0, 0, 8'h05, 8'h00, 1, 0, 1, 8'h30, 8'h00, 0, 1));
    tbl.push_back(mk("lk1_wr",   1, 0, 0, 8'h05, 8'h00, 1, 1, 1, 8'h30, 8'h31, 0, 1));
    tbl.push_back(mk("lk1_hold", 1, 0, 0, 8'h05, 8'h00, 0, 0, 1, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk("lk1_rel",  1, 0, 0, 8'h30, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 0));
    tbl.push_back(mk("idle_b",   0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk("idle_c",   0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk("idle_d",   0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk("tie_idle", 1, 0, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00, 0, 1));
    tbl.push_back(mk("lk0_rd",   1, 0, 1, 8'h03, 8'h00, 1, 0, 0, 8'h04, 8'h00, 1, 0));
    tbl.push_back(mk("lk0_wait", 0, 0, 1, 8'h00, 8'h00, 1, 0, 0, 8'h04, 8'h00, 0, 0));
    tbl.push_back(mk("lk0_drop", 1, 1, 0, 8'h50, 8'h77, 1, 0, 0, 8'h04, 8'h00, 0, 1));
    tbl.push_back(mk("wr0_50",   1, 1, 0, 8'h50, 8'h77, 0, 0, 0, 8'h00, 8'h00, 1, 0));
    tbl.push_back(mk("rd1_50",   0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h50, 8'h00, 0, 1));

    rst_n = 1'b0;
    req0 = 1'b1; we0 = 1'b1; lock0 = 1'b0; addr0 = 8'h11; wdata0 = 8'hEE;
    req1 = 1'b0; we1 = 1'b0; lock1 = 1'b0; addr1 = 8'h00; wdata1 = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst gnt0", gnt0, 0);
    chk("rst gnt1", gnt1, 0);
    chk("rst ram_we", ram_we, 0);
    chk("rst rvalid0", rvalid0, 0);
    chk("rst rvalid1", rvalid1, 0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Reset one cycle after a locked read: rvalid drops, lock is released.
    apply(mk("rst_lk0", 1, 0, 1, 8'h07, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 0));
    rst_n = 1'b0;
    we0 = 1'b1; wdata0 = 8'hDD;
    #1;
    chk("midrst rvalid0", rvalid0, 0);
    chk("midrst gnt0", gnt0, 0);
    chk("midrst ram_we", ram_we, 0);
    @(posedge clk);
    #1;
    chk("midrst held rvalid0", rvalid0, 0);
    chk("midrst held ram_we", ram_we, 0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(mk("post_rst_p1",  0, 0, 1, 8'h00, 8'h00, 1, 0, 0, 8'h07, 8'h00, 0, 1));
    apply(mk("post_rst_tie", 1, 0, 0, 8'h11, 8'h00, 1, 0, 0, 8'h02, 8'h00, 1, 0));
    apply(mk("drain",        0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single-port synchronous RAM between an instruction-fetch requester (port 0) and a load/store requester (port 1). Each cycle it grants at most one request to the RAM with round-robin fairness. It supports an atomic lock so a requester can hold the RAM across a read-modify-write sequence. Read data returns on the granted port one cycle after acceptance, matching the RAM's registered-address read.

## Interface
- `DataWidth`, default 8: data bus width, equal to the RAM's.
- `AddrWidth`, default 8: address width, equal to the RAM's.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req0` / `req1`  in  1  request valid.
- `we0` / `we1`  in  1  write (1) or read (0).
- `lock0` / `lock1`  in  1  hold exclusive grant after this transfer.
- `addr0` / `addr1`  in  AddrWidth  request address.
- `wdata0` / `wdata1`  in  DataWidth  write data.
- `gnt0` / `gnt1`  out  1  request accepted this cycle; combinational.
- `rvalid0` / `rvalid1`  out  1  read data valid; registered.
- `rdata0` / `rdata1`  out  DataWidth  read data; valid only while the matching `rvalidN` is high.
- `ram_addr`  out  AddrWidth  to RAM address.
- `ram_wdata`  out  DataWidth  to RAM write data.
- `ram_we`  out  1  to RAM write enable.
- `ram_data`  in  DataWidth  from RAM read data.

## Operation
- A transfer is accepted on a rising edge where `reqN && gntN`. At most one `gntN` is high per cycle.
- Requesters hold `reqN`, `weN`, `addrN`, `wdataN` and `lockN` stable until granted.
- Lock FSM states:
  - `OPEN`: normal arbitration.
  - `LOCK0`: only port 0 may be granted.
  - `LOCK1`: only port 1 may be granted.
- Arbitration in `OPEN`, and in `LOCKN` whenever `lockN` = 0 that cycle:
  - Only one requester: grant it.
  - Both requesting: grant the port not granted at the last accepted transfer.
  - Arbitration state `last_gnt` updates only on an accepted transfer.
- In `LOCKN` with `lockN` = 1, port N is granted if `reqN`; the other port is never granted, even if N is idle.
- Next state:
  - An accepted transfer on port N with `lockN` = 1 moves to `LOCKN`.
  - An accepted transfer with `lockN` = 0 moves to `OPEN`.
  - No accepted transfer while in `LOCKN` with `lockN` = 0 moves to `OPEN`.
  - Otherwise the state holds.
- RAM drive:
  - Granted cycle: `ram_addr`/`ram_wdata` come from the granted port, and `ram_we` = `weN` of the granted port.
  - No grant: `ram_addr` = 0, `ram_wdata` = 0, `ram_we` = 0.
- Read return:
  - An accepted read on port N sets `rvalidN` = 1 for exactly the next cycle.
  - `rdataN` = `ram_data` combinationally and is meaningful only while `rvalidN` = 1.
- Writes produce no `rvalid`; a write is complete at its acceptance edge.
- Back-to-back reads: one per cycle per port, fully pipelined.
- Write then read of the same address on consecutive cycles returns the new data.

## Timing
- Reset (asynchronous, while `rst_n` = 0):
  - state = `OPEN`, `last_gnt` = 1 (port 0 wins first tie).
  - `rvalid0` = `rvalid1` = 0.
  - `gnt*` = 0, `ram_we` = 0.
- Reset mid-operation: pending `rvalid` is dropped, lock is released, and no RAM write occurs in any cycle where `rst_n` is low.
- Grant latency: 0 cycles (same cycle as `reqN` when eligible).
- Read latency: data on `rdataN` with `rvalidN` 1 cycle after the acceptance edge.
- Fairness: with both ports continuously requesting unlocked, grants alternate 0,1,0,1. The worst-case wait is 1 cycle, unbounded only under a held lock.
- Simultaneous `lock` from both ports in `OPEN`: the round-robin winner takes the lock; the loser waits.

## Structure
- Shared package `ram_arb_pkg`:
  - state encoding `OPEN`/`LOCK0`/`LOCK1` (2 bits);
  - port index constants `PORT_IF` = 0, `PORT_LS` = 1.
- One sub-module `rr_pick2`: combinational 2-way round-robin picker with inputs `req[1:0]`, `last`, `mask[1:0]` and a one-hot `gnt[1:0]` output.
- The FSM, `last_gnt` and `rvalid` registers live in the top.

## Test plan
- Reset, then `req0` read at `addr` 0x10 (RAM[0x10] = 0xA5): `gnt0` = 1 same cycle; next cycle `rvalid0` = 1, `rdata0` = 0xA5, `rvalid1` = 0.
- Both ports request reads (`addr0` 0x01, `addr1` 0x02) for 4 cycles: grants 0,1,0,1; each `rvalid` one cycle after its grant with the correct data.
- Port 1 writes 0x3C to 0x20 while port 0 is idle, then port 0 reads 0x20 the next cycle: `rdata0` = 0x3C.
- Port 1 read 0x30 with `lock1` = 1, then write 0x31 to 0x30 with `lock1` = 0, while port 0 requests throughout: `gnt0` stays 0 until after the write; the state returns to `OPEN` and port 0 is granted the following cycle.
- Assert `rst_n` low one cycle after an accepted read with `lock0` = 1: `rvalid0` clears immediately; after release the state is `OPEN` and a port-1 request is granted at once.
- No requests for 3 cycles: `ram_we` = 0, `ram_addr` = 0, both `rvalid` = 0, `last_gnt` unchanged (checked by the next tie going to the expected port).
